// File: rtl/key_sched_pkg.sv
// Shared types and constants for the key event scheduler.
// Holds the repeat FSM states, default 50 MHz timing and index-width helper.
package key_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } rpt_state_e;

   localparam int REPEAT_DELAY_50M  = 12500000;
   localparam int REPEAT_PERIOD_50M = 5000000;

   function automatic int key_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/key_event_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr, with wrap-around.
// Purely combinational; gnt is one-hot, gnt_idx its binary index.
module rr_arbiter
   import key_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int KW = key_idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [KW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [KW-1:0] gnt_idx,
   output logic          gnt_vld
);

   always_comb begin
      int j;
      j       = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!gnt_vld && req[j]) begin
            gnt[j]  = 1'b1;
            gnt_idx = KW'(j);
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_event_scheduler.sv
// Turns debounced key levels into press and auto-repeat events,
// arbitrated round-robin onto one valid/ready event stream.
module key_event_scheduler
   import key_sched_pkg::*;
#(
   parameter int NUM_KEYS      = 4,
   parameter int CNT_W         = 24,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_50M,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_50M
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        enable,
   input  logic [NUM_KEYS-1:0]         keys_in,
   output logic                        event_valid,
   input  logic                        event_ready,
   output logic [$clog2(NUM_KEYS)-1:0] event_key,
   output logic                        event_repeat,
   output logic                        overrun
);

   localparam int KW = key_idx_w(NUM_KEYS);
   localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_TC = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [KW-1:0]    LAST   = KW'(NUM_KEYS - 1);

   logic [NUM_KEYS-1:0] keys_q;
   logic [NUM_KEYS-1:0] pending_q, pending_d;
   logic [NUM_KEYS-1:0] pend_rpt_q, pend_rpt_d;
   logic [NUM_KEYS-1:0] press, tick_vec, set_vec, clr_vec, gnt;
   rpt_state_e          state_q, state_d;
   logic [CNT_W-1:0]    timer_q, timer_d, tc;
   logic [KW-1:0]       held_q, held_d;
   logic [KW-1:0]       rr_q, rr_d;
   logic [KW-1:0]       key_q, key_d;
   logic [KW-1:0]       press_idx, gnt_idx;
   logic                valid_q, valid_d;
   logic                rpt_q, rpt_d;
   logic                ovr_q, ovr_d;
   logic                any_press, held_on, tick, gnt_vld, load;

   assign press     = keys_in & ~keys_q;
   assign any_press = |press;
   assign held_on   = keys_in[held_q];

   always_comb begin
      press_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (press[i]) press_idx = KW'(i);
      end
   end

   // A fresh press always retargets the timer; release beats a due tick.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      held_d  = held_q;
      tick    = 1'b0;
      tc      = (state_q == DELAY) ? DLY_TC : PER_TC;
      if (!enable) begin
         state_d = IDLE;
         timer_d = '0;
      end else if (any_press) begin
         state_d = DELAY;
         timer_d = '0;
         held_d  = press_idx;
      end else begin
         unique case (state_q)
            IDLE: ;
            DELAY, REPEAT: begin
               if (!held_on) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else if (timer_q == tc) begin
                  tick    = 1'b1;
                  timer_d = '0;
                  state_d = REPEAT;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   rr_arbiter #(
      .N  (NUM_KEYS),
      .KW (KW)
   ) u_arb (
      .req     (pending_q),
      .ptr     (rr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   assign load = enable && gnt_vld && (!valid_q || event_ready);

   // Sets are ORed in after the grant clear, so a same-edge set survives.
   always_comb begin
      tick_vec = '0;
      if (tick) tick_vec[held_q] = 1'b1;
      set_vec = enable ? (press | tick_vec) : '0;
      clr_vec = load ? gnt : '0;
      if (enable) begin
         pending_d  = (pending_q & ~clr_vec) | set_vec;
         pend_rpt_d = (pend_rpt_q | tick_vec) & ~press;
      end else begin
         pending_d  = '0;
         pend_rpt_d = '0;
      end
      ovr_d = enable && |(set_vec & pending_q & ~clr_vec);
   end

   always_comb begin
      valid_d = valid_q;
      key_d   = key_q;
      rpt_d   = rpt_q;
      rr_d    = rr_q;
      if (load) begin
         valid_d = 1'b1;
         key_d   = gnt_idx;
         rpt_d   = pend_rpt_q[gnt_idx];
         rr_d    = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      end else if (valid_q && event_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         keys_q     <= '0;
         pending_q  <= '0;
         pend_rpt_q <= '0;
         state_q    <= IDLE;
         timer_q    <= '0;
         held_q     <= '0;
         rr_q       <= '0;
         valid_q    <= 1'b0;
         key_q      <= '0;
         rpt_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         keys_q     <= keys_in;
         pending_q  <= pending_d;
         pend_rpt_q <= pend_rpt_d;
         state_q    <= state_d;
         timer_q    <= timer_d;
         held_q     <= held_d;
         rr_q       <= rr_d;
         valid_q    <= valid_d;
         key_q      <= key_d;
         rpt_q      <= rpt_d;
         ovr_q      <= ovr_d;
      end
   end

   assign event_valid  = valid_q;
   assign event_key    = key_q;
   assign event_repeat = rpt_q;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler with short repeat timing.
// Expected values are hand-derived cycle by cycle from the press edge.
module tb_key_event_scheduler;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       enable;
   logic [3:0] keys_in;
   logic       event_valid;
   logic       event_ready;
   logic [1:0] event_key;
   logic       event_repeat;
   logic       overrun;

   int checks   = 0;
   int failures = 0;

   key_event_scheduler #(
      .NUM_KEYS      (4),
      .CNT_W         (8),
      .REPEAT_DELAY  (8),
      .REPEAT_PERIOD (4)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .enable       (enable),
      .keys_in      (keys_in),
      .event_valid  (event_valid),
      .event_ready  (event_ready),
      .event_key    (event_key),
      .event_repeat (event_repeat),
      .overrun      (overrun)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      cyc();
      reset_n     = 1'b0;
      keys_in     = '0;
      enable      = 1'b1;
      event_ready = 1'b1;
      cyc();
      cyc();
      reset_n = 1'b1;
      cyc();
      cyc();
   endtask

   initial begin
      bit exp_v;
      reset_n     = 1'b0;
      enable      = 1'b1;
      keys_in     = '0;
      event_ready = 1'b1;
      #12;
      chk("rst_valid", event_valid, 0);
      chk("rst_key", event_key, 0);
      chk("rst_repeat", event_repeat, 0);
      chk("rst_overrun", overrun, 0);

      // single press, released before the first repeat
      do_reset();
      keys_in = 4'b0010;
      cyc();
      chk("t1_lat", event_valid, 0);
      cyc();
      chk("t1_valid", event_valid, 1);
      chk("t1_key", event_key, 1);
      chk("t1_rpt", event_repeat, 0);
      cyc();
      chk("t1_drop", event_valid, 0);
      keys_in = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("t1_quiet", event_valid, 0);
      end

      // simultaneous press, round-robin order, pointer wraps to 0
      do_reset();
      keys_in = 4'b1011;
      cyc();
      chk("t2_lat", event_valid, 0);
      cyc();
      chk("t2_v0", event_valid, 1);
      chk("t2_k0", event_key, 0);
      cyc();
      chk("t2_v1", event_valid, 1);
      chk("t2_k1", event_key, 1);
      cyc();
      chk("t2_v3", event_valid, 1);
      chk("t2_k3", event_key, 3);
      chk("t2_r3", event_repeat, 0);
      keys_in = 4'b0000;
      cyc();
      chk("t2_drop", event_valid, 0);
      keys_in = 4'b0101;
      cyc();
      cyc();
      chk("t2_ptr_k0", event_key, 0);
      chk("t2_ptr_v0", event_valid, 1);
      cyc();
      chk("t2_ptr_k2", event_key, 2);
      cyc();
      chk("t2_ptr_end", event_valid, 0);
      keys_in = 4'b0000;

      // backpressure and overrun coalescing
      do_reset();
      event_ready = 1'b0;
      keys_in = 4'b0100;
      cyc();
      chk("t3_lat", event_valid, 0);
      cyc();
      chk("t3_valid", event_valid, 1);
      chk("t3_key", event_key, 2);
      keys_in = 4'b0000;
      cyc();
      keys_in = 4'b0100;
      cyc();
      chk("t3_no_ovr", overrun, 0);
      chk("t3_hold_key", event_key, 2);
      keys_in = 4'b0000;
      cyc();
      keys_in = 4'b0100;
      cyc();
      chk("t3_ovr", overrun, 1);
      keys_in = 4'b0000;
      cyc();
      chk("t3_ovr_pulse", overrun, 0);
      chk("t3_hold_v", event_valid, 1);
      event_ready = 1'b1;
      cyc();
      chk("t3_next_v", event_valid, 1);
      chk("t3_next_k", event_key, 2);
      chk("t3_next_r", event_repeat, 0);
      cyc();
      chk("t3_empty", event_valid, 0);
      cyc();
      chk("t3_empty2", event_valid, 0);

      // auto-repeat on held key 3, released mid-period
      do_reset();
      keys_in = 4'b1000;
      cyc();
      chk("t4_lat", event_valid, 0);
      for (int c = 1; c <= 27; c++) begin
         cyc();
         exp_v = (c == 1 || c == 9 || c == 13 || c == 17);
         chk($sformatf("t4_valid_c%0d", c), event_valid, exp_v);
         if (exp_v) begin
            chk($sformatf("t4_key_c%0d", c), event_key, 3);
            chk($sformatf("t4_rpt_c%0d", c), event_repeat, c != 1);
         end
         if (c == 19) keys_in = 4'b0000;
      end

      // repeat retargets to the newest press
      do_reset();
      keys_in = 4'b0001;
      cyc();
      for (int c = 1; c <= 20; c++) begin
         cyc();
         exp_v = (c == 1 || c == 6 || c == 14);
         chk($sformatf("t5_valid_c%0d", c), event_valid, exp_v);
         if (exp_v) begin
            chk($sformatf("t5_key_c%0d", c), event_key, (c == 1) ? 0 : 2);
            chk($sformatf("t5_rpt_c%0d", c), event_repeat, c == 14);
         end
         if (c == 4) keys_in = 4'b0101;
         if (c == 16) keys_in = 4'b0000;
      end

      // asynchronous reset while a repeat event is held
      do_reset();
      keys_in = 4'b1000;
      cyc();
      repeat (9) cyc();
      chk("t6_pre_v", event_valid, 1);
      chk("t6_pre_r", event_repeat, 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("t6_async_v", event_valid, 0);
      chk("t6_async_k", event_key, 0);
      chk("t6_async_r", event_repeat, 0);
      chk("t6_async_o", overrun, 0);
      keys_in = 4'b0000;
      cyc();
      reset_n = 1'b1;
      cyc();

      // enable low flushes pending; held keys do not fire on re-enable
      event_ready = 1'b0;
      keys_in = 4'b1111;
      cyc();
      cyc();
      chk("t7_reg_v", event_valid, 1);
      chk("t7_reg_k", event_key, 0);
      enable = 1'b0;
      cyc();
      chk("t7_held_v", event_valid, 1);
      chk("t7_held_k", event_key, 0);
      event_ready = 1'b1;
      cyc();
      chk("t7_drain", event_valid, 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t7_flushed", event_valid, 0);
      end
      enable = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         chk("t7_no_event", event_valid, 0);
         chk("t7_no_ovr", overrun, 0);
      end
      keys_in = 4'b0000;
      cyc();
      keys_in = 4'b0010;
      cyc();
      cyc();
      chk("t7_after_v", event_valid, 1);
      chk("t7_after_k", event_key, 1);
      chk("t7_after_r", event_repeat, 0);
      keys_in = 4'b0000;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
